// File: rtl/decode_control_pipe.sv
// Instruction-decode stage: main control + ALU control decode behind valid/ready with a 2-entry skid buffer.
// Latency 1 cycle; in_ready is the registered inverse of the skid entry being full.
module decode_control_pipe #(
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instruction,
    output logic [7:0]       controls,
    output logic [3:0]       alu_control,
    output logic             illegal,
    output logic [CNT_W-1:0] decoded_count,
    output logic             illegal_seen
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_MUL = 4'b1100;

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  ctrl;
        logic [3:0]  alu;
        logic        ill;
    } entry_t;

    // {illegal, alu_control} for the funct7=0000000 funct3 table shared by R and I types
    function automatic logic [4:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = {1'b0, ALU_ADD};
            3'b001:  base_op = {1'b0, ALU_SLL};
            3'b010:  base_op = {1'b0, ALU_SLT};
            3'b100:  base_op = {1'b0, ALU_XOR};
            3'b101:  base_op = {1'b0, ALU_SRL};
            3'b110:  base_op = {1'b0, ALU_OR};
            3'b111:  base_op = {1'b0, ALU_AND};
            default: base_op = {1'b1, 4'b0000};
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [7:0] dec_base;
    logic [3:0] dec_alu;
    logic       dec_bad;
    logic [4:0] bop;
    entry_t     dec_entry;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    always_comb begin
        dec_base = 8'h00;
        dec_alu  = ALU_ADD;
        dec_bad  = 1'b0;
        bop      = base_op(funct3);
        case (opcode)
            7'b0110011: dec_base = 8'h22;
            7'b0000011: dec_base = 8'hF0;
            7'b0100011: dec_base = 8'h88;
            7'b1100011: dec_base = 8'h05;
            7'b0010011: dec_base = 8'hA3;
            default:    dec_bad  = 1'b1;
        endcase
        case (dec_base[1:0])
            2'b00: dec_alu = ALU_ADD;
            2'b01: dec_alu = ALU_SUB;
            2'b10: begin
                case (funct7)
                    7'b0000000: begin
                        dec_alu = bop[3:0];
                        dec_bad = bop[4];
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec_alu = ALU_SUB;
                        else if (funct3 == 3'b101) dec_alu = ALU_SRA;
                        else                       dec_bad = 1'b1;
                    end
                    7'b0000001: begin
                        if (ENABLE_M && funct3 == 3'b000) dec_alu = ALU_MUL;
                        else                              dec_bad = 1'b1;
                    end
                    default: dec_bad = 1'b1;
                endcase
            end
            2'b11: begin
                // I-type ignores funct7 except bit 5 selecting arithmetic right shift
                if (funct3 == 3'b101) begin
                    dec_alu = funct7[5] ? ALU_SRA : ALU_SRL;
                end else begin
                    dec_alu = bop[3:0];
                    dec_bad = bop[4];
                end
            end
            default: dec_alu = ALU_ADD;
        endcase
        dec_entry.instr = instruction;
        dec_entry.ctrl  = dec_bad ? 8'h00 : dec_base;
        dec_entry.alu   = dec_bad ? 4'b0000 : dec_alu;
        dec_entry.ill   = dec_bad;
    end

    entry_t main_q, skid_q;
    logic   main_vld, skid_vld;
    logic   accept, handshake, main_free;

    assign accept    = in_valid & ~skid_vld;
    assign handshake = main_vld & out_ready;
    assign main_free = ~main_vld | out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_q        <= '0;
            skid_q        <= '0;
            main_vld      <= 1'b0;
            skid_vld      <= 1'b0;
            decoded_count <= '0;
            illegal_seen  <= 1'b0;
        end else begin
            if (handshake) begin
                decoded_count <= decoded_count + CNT_W'(1);
                if (main_q.ill) illegal_seen <= 1'b1;
            end
            if (flush) begin
                main_vld <= 1'b0;
                skid_vld <= 1'b0;
            end else if (main_free) begin
                // skid is only ever full while in_ready is low, so it never races an accept
                if (skid_vld) begin
                    main_q   <= skid_q;
                    main_vld <= 1'b1;
                    skid_vld <= 1'b0;
                end else begin
                    main_vld <= accept;
                    if (accept) main_q <= dec_entry;
                end
            end else if (accept) begin
                skid_q   <= dec_entry;
                skid_vld <= 1'b1;
            end
        end
    end

    assign in_ready        = ~skid_vld;
    assign out_valid       = main_vld;
    assign out_instruction = main_q.instr;
    assign controls        = main_q.ctrl;
    assign alu_control     = main_q.alu;
    assign illegal         = main_q.ill;

endmodule
